// File: rtl/backup_sram_streamer.sv
// backup_sram_streamer
//   Moves a full backup image between the host save-file bridge and port B
//   of the backup RAM, all in the clk_sys domain.
//   LOAD : bridge words (in_data/in_valid/in_ready) are written to
//          consecutive RAM word addresses.
//   SAVE : consecutive RAM words are read and handed to the bridge through
//          a small skid FIFO (out_data/out_valid/out_ready).
//
// Handshake rule: a word moves on a rising clk_sys edge exactly when valid
// and ready are both high in the preceding cycle. A valid source holds its
// data stable until that happens. out_valid/out_data obey this rule.
//
// Ports
//   clk_sys, reset (async, active high)
//   load_start, save_start : one-cycle start pulses, honoured only in IDLE
//   abort                  : back to IDLE at the next edge, drop in-flight data
//   busy, done             : status; done pulses once per completed transfer
//   in_data/in_valid/in_ready    : LOAD stream from the bridge
//   out_data/out_valid/out_ready : SAVE stream to the bridge
//   sram_addr/sram_wr/sram_wdata : RAM port-B request (byte address)
//   ram_rdata                    : RAM port-B read data, RD_LAT cycles late
module backup_sram_streamer #(
  parameter int WORDS      = 16384,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load_start,
  input  logic        save_start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sram_addr,
  output logic        sram_wr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int CW = $clog2(WORDS + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + FIFO_DEPTH + 2) + 1;

  localparam logic [CW-1:0] WORDS_C  = CW'(WORDS);
  localparam logic [CW-1:0] LAST_C   = CW'(WORDS - 1);
  localparam logic [OW-1:0] DEPTH_C  = OW'(FIFO_DEPTH);
  localparam logic [IW-1:0] CREDIT_C = IW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SAVE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     rcnt;
  logic [CW-1:0]     acnt;
  // rd_issued marks the cycle an address is on sram_addr; rd_tag delays that
  // mark so rd_tag[RD_LAT-1] lines up with the matching ram_rdata.
  logic              rd_issued;
  logic [RD_LAT-1:0] rd_tag;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     count;

  logic              load_hs;
  logic              push;
  logic              pop;
  logic              issue;
  logic [IW-1:0]     inflight;
  logic [IW-1:0]     credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] word_addr(input logic [CW-1:0] w);
    logic [CW+1:0] b;
    b = {w, 2'b00};
    return 16'(b);
  endfunction

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign load_hs   = in_ready & in_valid;
  assign pop       = out_valid & out_ready;
  assign push      = rd_tag[RD_LAT-1];

  // Every read on its way (address out or data in the delay line) plus every
  // stored word owns a FIFO slot; a slot freed by this cycle's pop is reusable
  // at once, which keeps one read per cycle going with out_ready held high.
  always_comb begin
    inflight = IW'(rd_issued);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + IW'(rd_tag[i]);
    end
    credit_used = inflight + IW'(count) - IW'(pop);
    issue = (state == S_SAVE) && (rcnt < WORDS_C) &&
            (credit_used < CREDIT_C) && !abort;
  end

  always_ff @(posedge clk_sys) begin
    if (push && !abort) begin
      fifo_mem[wr_ptr] <= ram_rdata;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      rcnt       <= '0;
      acnt       <= '0;
      rd_issued  <= 1'b0;
      rd_tag     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sram_addr  <= '0;
      sram_wr    <= 1'b0;
      sram_wdata <= '0;
      done       <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      rd_issued <= 1'b0;
      rd_tag    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sram_wr   <= 1'b0;
      done      <= 1'b0;
    end else begin
      sram_wr   <= 1'b0;
      done      <= 1'b0;
      rd_issued <= issue;
      rd_tag[0] <= rd_issued;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_tag[i] <= rd_tag[i-1];
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + OW'(push) - OW'(pop);

      case (state)
        S_IDLE: begin
          if (load_start) begin
            state <= S_LOAD;
            wcnt  <= '0;
          end else if (save_start) begin
            // Word 0 is requested on the start edge itself, so the first
            // word reaches the bridge RD_LAT+1 edges after save_start.
            state     <= S_SAVE;
            sram_addr <= '0;
            rd_issued <= 1'b1;
            rcnt      <= CW'(1);
            acnt      <= '0;
          end
        end
        S_LOAD: begin
          if (load_hs) begin
            sram_wr    <= 1'b1;
            sram_wdata <= in_data;
            sram_addr  <= word_addr(wcnt);
            wcnt       <= wcnt + 1'b1;
            if (wcnt == LAST_C) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: begin
          if (issue) begin
            sram_addr <= word_addr(rcnt);
            rcnt      <= rcnt + 1'b1;
          end
          if (pop) begin
            acnt <= acnt + 1'b1;
            if (acnt == LAST_C) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk_sys) disable iff (reset)
    !(push && !abort && count == DEPTH_C));

endmodule

// File: tb/tb_backup_sram_streamer.sv
// Bench for backup_sram_streamer: directed LOAD/SAVE/abort/reset scenarios.
// Drivers push expected RAM writes and bridge words into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_backup_sram_streamer;
  localparam int WORDS      = 512;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = 9;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        load_start, save_start, abort;
  logic        busy, done;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic [15:0] sram_addr;
  logic        sram_wr;
  logic [31:0] sram_wdata;
  logic [31:0] ram_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [47:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem [WORDS];
  logic [31:0] rp0, rp1;
  int          wr_cnt, pop_cnt, done_cnt;
  bit          stab_en;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  backup_sram_streamer #(
    .WORDS(WORDS), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .load_start(load_start), .save_start(save_start), .abort(abort),
    .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sram_addr(sram_addr), .sram_wr(sram_wr), .sram_wdata(sram_wdata),
    .ram_rdata(ram_rdata)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  // RAM port B read model: data appears RD_LAT cycles after the address.
  always @(posedge clk_sys) begin
    rp0 <= mem[sram_addr[LW+1:2]];
    rp1 <= rp0;
  end
  assign ram_rdata = rp1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (sram_wr) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL write_without_handshake: got addr %0h data %0h expected no write",
                   sram_addr, sram_wdata);
        end else begin
          check("write_addr_data", {sram_addr, sram_wdata}, wr_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out_word: got %0h expected none", out_data);
        end else begin
          check("out_word", out_data, exp_q.pop_front());
        end
      end
      if (stab_en && prev_stall) check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) done_cnt++;
      if (busy) check("addr_range", 128'(sram_addr <= 16'((WORDS - 1) * 4)), 128'd1);
    end
  end

  // driver tasks
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic start_save();
    for (int i = 0; i < WORDS; i++) exp_q.push_back(mem[i]);
    pop_cnt    = 0;
    done_cnt   = 0;
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
  endtask

  task automatic do_load(input bit rnd);
    int idx;
    int n;
    wr_q.delete();
    wr_cnt     = 0;
    done_cnt   = 0;
    idx        = 0;
    n          = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    while (idx < WORDS && n < WORDS * 4) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 32'hA500_0000 + 32'(idx);
      @(negedge clk_sys);
      if (in_valid && in_ready) begin
        wr_q.push_back({16'(idx * 4), in_data});
        idx++;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("load_accepted", 128'(idx), 128'(WORDS));
    wait_done(8, n);
    check("load_done_latency", 128'(n), 128'd1);
    check("load_busy_at_done", busy, 1'b0);
    tick();
    tick();
    check("load_write_count", 128'(wr_cnt), 128'(WORDS));
    check("load_queue_empty", 128'(wr_q.size()), 128'd0);
    check("load_done_pulses", 128'(done_cnt), 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    int occ;
    int max_occ;
    for (int i = 0; i < WORDS; i++) mem[i] = 32'(i) ^ 32'h5A5A_5A5A;
    reset = 1'b1; load_start = 1'b0; save_start = 1'b0; abort = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0; stab_en = 1'b1;
    #2;
    check("reset_outputs",
          {busy, done, in_ready, out_valid, sram_wr, sram_addr, sram_wdata, out_data}, '0);
    @(posedge clk_sys); #1; tick();
    reset = 1'b0;
    tick();

    // LOAD, in_valid held high, then a random 50% valid pattern
    do_load(1'b0);
    do_load(1'b1);

    // SAVE at full rate
    out_ready = 1'b1;
    start_save();
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("save_first_latency", 128'(lat), 128'(RD_LAT + 1));
    wait_done(WORDS + 20, n);
    check("save_full_rate_cycles", 128'(n), 128'(WORDS));
    tick(); tick();
    check("save_pop_count", 128'(pop_cnt), 128'(WORDS));
    check("save_queue_empty", 128'(exp_q.size()), 128'd0);
    check("save_done_pulses", 128'(done_cnt), 128'd1);
    check("save_busy_after", busy, 1'b0);

    // SAVE with out_ready one cycle in five
    out_ready = 1'b0;
    start_save();
    n = 0;
    max_occ = 0;
    while (!done && n < WORDS * 6) begin
      out_ready = ((n % 5) == 4);
      #1;
      occ = int'(sram_addr >> 2) + 1 - pop_cnt;
      if (occ > max_occ) max_occ = occ;
      @(posedge clk_sys);
      #1;
      n++;
    end
    out_ready = 1'b0;
    check("slow_done_seen", done, 1'b1);
    tick(); tick();
    check("slow_pop_count", 128'(pop_cnt), 128'(WORDS));
    check("slow_queue_empty", 128'(exp_q.size()), 128'd0);
    check("slow_max_outstanding", 128'(max_occ), 128'(FIFO_DEPTH));

    // abort at word 100 of a SAVE, then restart immediately
    out_ready = 1'b1;
    start_save();
    n = 0;
    while (pop_cnt < 100 && n < 400) begin
      tick();
      n++;
    end
    check("abort_reached_word_100", 128'(pop_cnt), 128'd100);
    stab_en   = 1'b0;
    out_ready = 1'b0;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_out_valid_drop", {busy, out_valid, done}, 3'b000);
    check("abort_no_done", 128'(done_cnt), 128'd0);
    exp_q.delete();
    start_save();
    check("restart_addr_zero", sram_addr, 16'h0000);
    out_ready = 1'b1;
    stab_en   = 1'b1;
    wait_done(WORDS + 40, n);
    check("restart_cycles", 128'(n), 128'(WORDS + RD_LAT + 1));
    tick(); tick();
    check("restart_pop_count", 128'(pop_cnt), 128'(WORDS));
    check("restart_queue_empty", 128'(exp_q.size()), 128'd0);
    out_ready = 1'b0;

    // abort together with a start pulse in IDLE
    abort = 1'b1; load_start = 1'b1;
    tick();
    abort = 1'b0; load_start = 1'b0;
    check("abort_beats_start", {busy, in_ready}, 2'b00);

    // both starts together: LOAD wins; then async reset mid-LOAD
    load_start = 1'b1; save_start = 1'b1;
    tick();
    load_start = 1'b0; save_start = 1'b0;
    check("load_priority", {busy, in_ready}, 2'b11);
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA500_0000 + 32'(i);
      @(negedge clk_sys);
      if (in_valid && in_ready) wr_q.push_back({16'(i * 4), in_data});
      tick();
    end
    @(negedge clk_sys);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {busy, done, in_ready, out_valid, sram_wr, sram_addr, sram_wdata, out_data}, '0);
    check("mid_load_writes_seen", 128'(wr_q.size()), 128'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("idle_after_reset", {busy, sram_wr}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
